probe_uplink_arbiter: RTL
=========================

Name: probe_uplink_arbiter

Overview:
- Collects uplink words from NumProbes probe-value stages, each exposing DATAVALID/DATAUP/ACK/DELAY, and merges them into one framed 32-bit stream toward the serial uplink transmitter.
- Grants one probe at a time (round-robin) and holds the grant for the whole packet. A packet is a header word plus N data words, where N = header[7:0].
- Buffers accepted words in a small FIFO with valid/ready output and a last-word flag.

Parameters:
- NumProbes, 4, number of probe uplink ports (1..16).
- FifoDepth, 4, output FIFO entries (power of two, >=2).

Ports:
- UCLK  input  1  uplink clock; all logic on rising edge.
- URST  input  1  asynchronous, active-high reset.
- DATAVALID  input  NumProbes  per-probe word-valid; bit i = probe i.
- DATAUP  input  32*NumProbes  per-probe word; probe i at [32*i+31:32*i].
- DELAY  input  NumProbes  per-probe pending-data indication.
- ACK  output  NumProbes  one-cycle accept of the granted probe's current word.
- DELAYOUT  output  1  OR of DELAY, registered.
- OUTDATA  output  32  FIFO head word.
- OUTLAST  output  1  FIFO head is the final word of its packet.
- OUTVALID  output  1  FIFO non-empty.
- OUTREADY  input  1  consumer accepts head when OUTVALID&OUTREADY.
- ABORT  output  1  one-cycle pulse when the granted probe drops DATAVALID mid-packet.

Behaviour:
- Reset (async, URST=1):
  - state=IDLE, grant=0, rr pointer=0, remaining=0.
  - FIFO empty; OUTVALID=0, OUTDATA=0, OUTLAST=0.
  - ACK=0, ABORT=0, DELAYOUT=0.
- Probe protocol: a probe holds DATAVALID and DATAUP until ACKed. DATAUP changes on the edge where ACK is sampled, and the new word is visible the next cycle. The final ACK of a packet drops DATAVALID on the same edge.
- States: IDLE, HEADER, BODY.
- IDLE:
  - Pick the lowest index j at or after the rr pointer (modulo NumProbes) with DATAVALID[j]=1.
  - Register grant=j and go to HEADER next cycle. No ACK is issued in IDLE.
  - If no request, stay in IDLE.
- HEADER:
  - push = DATAVALID[grant] & !fifo_full.
  - ACK[grant] = push, combinational. The FIFO writes DATAUP[grant] on that edge and remaining <= DATAUP[grant][7:0].
  - If [7:0]==0, write OUTLAST=1 and go to IDLE. Otherwise write OUTLAST=0 and go to BODY.
  - If fifo_full, wait with no ACK.
- BODY:
  - Same push/ACK rule.
  - Each push decrements remaining. The push with remaining==1 writes OUTLAST=1 and goes to IDLE.
- On every transition to IDLE, set rr pointer = grant+1 (wrap at NumProbes). The finishing probe therefore has lowest priority next.
- Abort: in HEADER or BODY, if DATAVALID[grant]=0, pulse ABORT for one cycle, go to IDLE, and advance the rr pointer. Words already pushed remain in the FIFO without OUTLAST.
- ACK has at most one bit set, and only in HEADER/BODY. Throughput is 1 word/cycle while the FIFO has space. There is one idle cycle between packets.
- FIFO:
  - Simultaneous push and pop are allowed when full or empty. Pop frees space combinationally for the same-cycle push: fifo_full means count==FifoDepth and !(OUTVALID&OUTREADY).
  - OUTDATA/OUTLAST are stable while OUTVALID&!OUTREADY.
  - Count width is clog2(FifoDepth)+1. Pointers wrap modulo FifoDepth.
- DELAYOUT <= |DELAY every cycle.

Test Plan:
- Single packet, header only: probe 0 presents 0x0003_0000 with OUTREADY=1 → one ACK[0], FIFO word 0x00030000 with OUTLAST=1, state returns to IDLE.
- Multi-word: probe 2 presents header 0x0002_0002, then 0xDEADBEEF, then 0x12345678 → ACK[2] pulses 3 times on consecutive cycles; output 3 words with OUTLAST only on 0x12345678.
- Round-robin: probes 0 and 1 request continuously with 1-word packets (header count 1) → grants alternate 0,1,0,1; no probe gets two consecutive packets.
- Backpressure: OUTREADY=0 with FifoDepth=4 and a 6-word packet → exactly 4 ACKs, then none. Releasing OUTREADY resumes ACKs the same cycle as the first pop; all 6 words are delivered in order.
- Abort: probe 1 drops DATAVALID after 1 of 3 body words → ABORT pulses once, FIFO holds header + 1 word with no OUTLAST, and the next grant goes to probe 2 (or the next requester).
- Async reset mid-BODY: assert URST between edges → ACK=0 and OUTVALID=0 immediately. After release, state is IDLE and the rr pointer is 0.

Source files
------------

// File: rtl/probe_uplink_arbiter.sv
// Round-robin packet arbiter merging probe uplink words into one framed 32-bit stream.
// The grant is held for a whole packet; accepted words go through a small FIFO toward the uplink.
module probe_uplink_arbiter #(
   parameter int NumProbes = 4,
   parameter int FifoDepth = 4
) (
   input  logic                      UCLK,
   input  logic                      URST,
   input  logic [NumProbes-1:0]      DATAVALID,
   input  logic [32*NumProbes-1:0]   DATAUP,
   input  logic [NumProbes-1:0]      DELAY,
   output logic [NumProbes-1:0]      ACK,
   output logic                      DELAYOUT,
   output logic [31:0]               OUTDATA,
   output logic                      OUTLAST,
   output logic                      OUTVALID,
   input  logic                      OUTREADY,
   output logic                      ABORT
);

   localparam int GW = (NumProbes > 1) ? $clog2(NumProbes) : 1;
   localparam int AW = $clog2(FifoDepth);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_HEADER = 2'd1;
   localparam logic [1:0] ST_BODY   = 2'd2;

   logic [1:0]             state_r;
   logic [GW-1:0]          grant_r;
   logic [GW-1:0]          rr_r;
   logic [7:0]             remaining_r;

   logic [2*NumProbes-1:0] rot_s;
   logic [GW:0]            off_s;
   logic [GW:0]            sum_s;
   logic [GW-1:0]          pick_s;
   logic [GW-1:0]          rr_next_s;
   logic                   found_s;

   logic                   sel_valid_s;
   logic [31:0]            sel_data_s;
   logic                   active_s;
   logic                   push_s;
   logic                   pop_s;
   logic                   last_s;
   logic                   fifo_full_s;
   logic                   abort_s;

   logic [32:0]            mem_r [FifoDepth];
   logic [AW-1:0]          wr_ptr_r;
   logic [AW-1:0]          rd_ptr_r;
   logic [AW:0]            count_r;

   assign OUTVALID = (count_r != '0);
   assign OUTDATA  = mem_r[rd_ptr_r][31:0];
   assign OUTLAST  = mem_r[rd_ptr_r][32];

   // Round-robin pick: rotate requests so the pointer lands at bit 0, take the lowest set offset.
   always_comb begin
      rot_s   = {DATAVALID, DATAVALID} >> rr_r;
      off_s   = '0;
      found_s = 1'b0;
      for (int k = NumProbes - 1; k >= 0; k--) begin
         off_s   = rot_s[k] ? (GW+1)'(k) : off_s;
         found_s = found_s | rot_s[k];
      end
      sum_s     = {1'b0, rr_r} + off_s;
      pick_s    = (sum_s >= (GW+1)'(NumProbes)) ? GW'(sum_s - (GW+1)'(NumProbes)) : sum_s[GW-1:0];
      rr_next_s = (grant_r == GW'(NumProbes - 1)) ? '0 : grant_r + GW'(1);
   end

   // Granted-probe datapath; a same-cycle pop frees a slot for the push.
   always_comb begin
      sel_valid_s = DATAVALID[grant_r];
      sel_data_s  = DATAUP[{grant_r, 5'd0} +: 32];
      active_s    = (state_r == ST_HEADER) || (state_r == ST_BODY);
      pop_s       = OUTVALID & OUTREADY;
      fifo_full_s = (count_r == (AW+1)'(FifoDepth)) && !pop_s;
      push_s      = active_s && sel_valid_s && !fifo_full_s;
      abort_s     = active_s && !sel_valid_s;
      last_s      = (state_r == ST_HEADER) ? (sel_data_s[7:0] == 8'd0) : (remaining_r == 8'd1);
      ACK          = '0;
      ACK[grant_r] = push_s;
   end

   // Packet framing state machine; every return to idle moves the pointer past the grant.
   always_ff @(posedge UCLK or posedge URST) begin
      if (URST) begin
         state_r     <= ST_IDLE;
         grant_r     <= '0;
         rr_r        <= '0;
         remaining_r <= 8'd0;
         ABORT       <= 1'b0;
      end else begin
         ABORT <= abort_s;
         case (state_r)
            ST_IDLE: begin
               if (found_s) begin
                  grant_r <= pick_s;
                  state_r <= ST_HEADER;
               end
            end
            ST_HEADER, ST_BODY: begin
               if (abort_s) begin
                  state_r <= ST_IDLE;
                  rr_r    <= rr_next_s;
               end else if (push_s) begin
                  remaining_r <= (state_r == ST_HEADER) ? sel_data_s[7:0] : remaining_r - 8'd1;
                  if (last_s) begin
                     state_r <= ST_IDLE;
                     rr_r    <= rr_next_s;
                  end else begin
                     state_r <= ST_BODY;
                  end
               end
            end
            default: state_r <= ST_IDLE;
         endcase
      end
   end

   // Output FIFO storage and occupancy.
   always_ff @(posedge UCLK or posedge URST) begin
      if (URST) begin
         for (int i = 0; i < FifoDepth; i++) begin
            mem_r[i] <= 33'd0;
         end
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         if (push_s) begin
            mem_r[wr_ptr_r] <= {last_s, sel_data_s};
            wr_ptr_r        <= wr_ptr_r + AW'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         count_r <= count_r + (AW+1)'(push_s) - (AW+1)'(pop_s);
      end
   end

   // Registered summary of the probes' pending-data flags.
   always_ff @(posedge UCLK or posedge URST) begin
      if (URST) begin
         DELAYOUT <= 1'b0;
      end else begin
         DELAYOUT <= |DELAY;
      end
   end

endmodule
